ctrl_frame_port_arbiter: RTL and testbench

// - Shares one control-frame fetcher among NPORTS ingress ports. Each port has its own

---
 rtl/ctrl_frame_port_arbiter.sv | 115 +++++++++++
 tb/tb_ctrl_frame_port_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_frame_port_arbiter.sv
// Round-robin arbiter sharing one control-frame fetcher among NPORTS ingress ports.
// A grant is taken per frame and held until the fetcher pops the header.
module ctrl_frame_port_arbiter #(
    parameter int unsigned NPORTS        = 4,
    parameter int unsigned HEADER_DWIDTH = 128,
    parameter int unsigned CTRL_BIT      = 114
) (
    input  logic                              clk,
    input  logic                              arst_n,
    input  logic [NPORTS*HEADER_DWIDTH-1:0]   p_h_dout,
    input  logic [NPORTS-1:0]                 p_h_empty,
    output logic [NPORTS-1:0]                 p_h_rden,
    input  logic [NPORTS*8-1:0]               p_b_dout,
    input  logic [NPORTS-1:0]                 p_b_empty,
    input  logic [NPORTS-1:0]                 p_b_del,
    output logic [NPORTS-1:0]                 p_b_rden,
    output logic [HEADER_DWIDTH-1:0]          f_h_dout,
    output logic                              f_h_empty,
    input  logic                              f_h_rden,
    output logic [7:0]                        f_b_dout,
    output logic                              f_b_empty,
    output logic                              f_b_del,
    input  logic                              f_b_rden,
    output logic                              gnt_valid,
    output logic [2:0]                        gnt_idx,
    output logic [15:0]                       frame_cnt,
    output logic                              err_stray_rd
);

    typedef enum logic {S_IDLE, S_LOCK} state_t;

    state_t            state;
    logic [2:0]        rr_ptr;
    logic [NPORTS-1:0] req;
    logic              sel_found;
    logic [2:0]        sel_idx;

    always_comb begin
        req = '0;
        for (int unsigned i = 0; i < NPORTS; i++)
            req[i] = ~p_h_empty[i] & p_h_dout[i*HEADER_DWIDTH + CTRL_BIT];
    end

    // Scan positions rr_ptr, rr_ptr+1, ... (mod NPORTS); the first requesting port wins.
    always_comb begin
        int unsigned pos;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int unsigned k = 0; k < NPORTS; k++) begin
            pos = 32'(rr_ptr) + k;
            if (pos >= NPORTS)
                pos = pos - NPORTS;
            for (int unsigned i = 0; i < NPORTS; i++) begin
                if (!sel_found && req[i] && (i == pos)) begin
                    sel_found = 1'b1;
                    sel_idx   = 3'(i);
                end
            end
        end
    end

    always_comb begin
        f_h_dout  = '0;
        f_h_empty = 1'b1;
        f_b_dout  = '0;
        f_b_empty = 1'b1;
        f_b_del   = 1'b0;
        p_h_rden  = '0;
        p_b_rden  = '0;
        for (int unsigned i = 0; i < NPORTS; i++) begin
            if (gnt_valid && (gnt_idx == 3'(i))) begin
                f_h_dout    = p_h_dout[i*HEADER_DWIDTH +: HEADER_DWIDTH];
                f_h_empty   = p_h_empty[i];
                f_b_dout    = p_b_dout[i*8 +: 8];
                f_b_empty   = p_b_empty[i];
                f_b_del     = p_b_del[i];
                p_h_rden[i] = f_h_rden;
                p_b_rden[i] = f_b_rden;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state        <= S_IDLE;
            gnt_valid    <= 1'b0;
            gnt_idx      <= '0;
            rr_ptr       <= '0;
            frame_cnt    <= '0;
            err_stray_rd <= 1'b0;
        end else begin
            if (!gnt_valid && (f_h_rden || f_b_rden))
                err_stray_rd <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (sel_found) begin
                        gnt_idx   <= sel_idx;
                        gnt_valid <= 1'b1;
                        state     <= S_LOCK;
                    end
                end
                S_LOCK: begin
                    if (f_h_rden) begin
                        gnt_valid <= 1'b0;
                        rr_ptr    <= (gnt_idx == 3'(NPORTS-1)) ? 3'd0 : gnt_idx + 3'd1;
                        frame_cnt <= frame_cnt + 16'd1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_frame_port_arbiter.sv
// Directed bench for ctrl_frame_port_arbiter: reset, round-robin order, lock hold,
// stray reads and asynchronous reset mid-frame.
module tb_ctrl_frame_port_arbiter;

    localparam int unsigned NP = 4;
    localparam int unsigned HW = 128;

    logic             clk = 1'b0;
    logic             arst_n;
    logic [NP*HW-1:0] p_h_dout;
    logic [NP-1:0]    p_h_empty;
    logic [NP-1:0]    p_h_rden;
    logic [NP*8-1:0]  p_b_dout;
    logic [NP-1:0]    p_b_empty;
    logic [NP-1:0]    p_b_del;
    logic [NP-1:0]    p_b_rden;
    logic [HW-1:0]    f_h_dout;
    logic             f_h_empty;
    logic             f_h_rden;
    logic [7:0]       f_b_dout;
    logic             f_b_empty;
    logic             f_b_del;
    logic             f_b_rden;
    logic             gnt_valid;
    logic [2:0]       gnt_idx;
    logic [15:0]      frame_cnt;
    logic             err_stray_rd;

    logic [HW-1:0]    h_word [NP];
    logic [7:0]       b_byte [NP];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NP; i++) begin
            p_h_dout[i*HW +: HW] = h_word[i];
            p_b_dout[i*8 +: 8]   = b_byte[i];
        end
    end

    ctrl_frame_port_arbiter #(
        .NPORTS        (NP),
        .HEADER_DWIDTH (HW),
        .CTRL_BIT      (114)
    ) dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .p_h_dout     (p_h_dout),
        .p_h_empty    (p_h_empty),
        .p_h_rden     (p_h_rden),
        .p_b_dout     (p_b_dout),
        .p_b_empty    (p_b_empty),
        .p_b_del      (p_b_del),
        .p_b_rden     (p_b_rden),
        .f_h_dout     (f_h_dout),
        .f_h_empty    (f_h_empty),
        .f_h_rden     (f_h_rden),
        .f_b_dout     (f_b_dout),
        .f_b_empty    (f_b_empty),
        .f_b_del      (f_b_del),
        .f_b_rden     (f_b_rden),
        .gnt_valid    (gnt_valid),
        .gnt_idx      (gnt_idx),
        .frame_cnt    (frame_cnt),
        .err_stray_rd (err_stray_rd)
    );

    task automatic chk(input string tag, input logic [HW-1:0] got, input logic [HW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [HW-1:0] hdr(input int p, input logic ctrl);
        logic [HW-1:0] w;
        w      = {4{32'hA500_0000 + 32'(p)}};
        w[114] = ctrl;
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ports();
        for (int i = 0; i < NP; i++) begin
            h_word[i] = hdr(i, 1'b0);
            b_byte[i] = 8'(8'h10 + i);
        end
        p_h_empty = '1;
        p_b_empty = '1;
        p_b_del   = '0;
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        tick();
        arst_n = 1'b1;
    endtask

    // One-cycle header pop from the fetcher, which ends the current frame.
    task automatic pop_hdr();
        f_h_rden = 1'b1;
        tick();
        f_h_rden = 1'b0;
        #1;
    endtask

    int exp_order [6] = '{0, 1, 3, 0, 1, 3};

    initial begin
        f_h_rden = 1'b0;
        f_b_rden = 1'b0;
        idle_ports();
        arst_n = 1'b0;
        #2;
        chk("rst_gnt_valid", 128'(gnt_valid), 128'd0);
        chk("rst_gnt_idx", 128'(gnt_idx), 128'd0);
        chk("rst_frame_cnt", 128'(frame_cnt), 128'd0);
        chk("rst_err", 128'(err_stray_rd), 128'd0);
        chk("rst_f_h_empty", 128'(f_h_empty), 128'd1);
        chk("rst_rden", 128'({p_h_rden, p_b_rden}), 128'd0);
        do_reset();

        // Only port 2 holds a control head.
        h_word[2]    = hdr(2, 1'b1);
        p_h_empty[2] = 1'b0;
        b_byte[2]    = 8'h5A;
        p_b_empty[2] = 1'b0;
        p_b_del[2]   = 1'b1;
        tick();
        chk("p2_gnt_valid", 128'(gnt_valid), 128'd1);
        chk("p2_gnt_idx", 128'(gnt_idx), 128'd2);
        chk("p2_f_h_dout", f_h_dout, hdr(2, 1'b1));
        chk("p2_f_body", 128'({f_b_dout, f_b_empty, f_b_del}), 128'({8'h5A, 1'b0, 1'b1}));
        f_h_rden = 1'b1;
        #1;
        chk("p2_p_h_rden", 128'(p_h_rden), 128'b0100);
        tick();
        f_h_rden     = 1'b0;
        p_h_empty[2] = 1'b1;
        #1;
        chk("p2_frame_cnt", 128'(frame_cnt), 128'd1);
        chk("p2_released", 128'(gnt_valid), 128'd0);
        chk("p2_idle_f_h_dout", f_h_dout, 128'd0);

        // Ports 0, 1, 3 request continuously from rr_ptr=0.
        idle_ports();
        for (int i = 0; i < NP; i++) h_word[i] = hdr(i, 1'b1);
        p_h_empty = 4'b0100;
        do_reset();
        tick();
        for (int f = 0; f < 6; f++) begin
            chk("rr_gnt_valid", 128'(gnt_valid), 128'd1);
            chk("rr_gnt_idx", 128'(gnt_idx), 128'(exp_order[f]));
            pop_hdr();
            chk("rr_idle_gap", 128'(gnt_valid), 128'd0);
            tick();
        end
        chk("rr_frame_cnt", 128'(frame_cnt), 128'd6);

        // Non-control head on port 1 is never granted; port 3 is.
        idle_ports();
        h_word[1] = hdr(1, 1'b0);
        h_word[3] = hdr(3, 1'b1);
        p_h_empty = 4'b0101;
        do_reset();
        tick();
        chk("nc_gnt_idx", 128'({gnt_valid, gnt_idx}), 128'({1'b1, 3'd3}));
        p_h_empty[3] = 1'b1;
        pop_hdr();
        tick();
        tick();
        tick();
        chk("nc_no_grant", 128'(gnt_valid), 128'd0);

        // Grant held on port 0 after its head empties, then moves to port 2.
        idle_ports();
        h_word[0] = hdr(0, 1'b1);
        p_h_empty = 4'b1110;
        do_reset();
        tick();
        chk("hold_first", 128'({gnt_valid, gnt_idx}), 128'({1'b1, 3'd0}));
        h_word[2]    = hdr(2, 1'b1);
        p_h_empty    = 4'b1011;
        tick();
        tick();
        chk("hold_kept", 128'({gnt_valid, gnt_idx}), 128'({1'b1, 3'd0}));
        chk("hold_f_h_empty", 128'(f_h_empty), 128'd1);
        pop_hdr();
        chk("hold_idle", 128'(gnt_valid), 128'd0);
        tick();
        chk("hold_moved", 128'({gnt_valid, gnt_idx}), 128'({1'b1, 3'd2}));
        p_h_empty[2] = 1'b1;
        pop_hdr();

        // Stray body read while idle.
        chk("stray_pre_err", 128'(err_stray_rd), 128'd0);
        f_b_rden = 1'b1;
        #1;
        chk("stray_p_b_rden", 128'(p_b_rden), 128'd0);
        tick();
        f_b_rden = 1'b0;
        chk("stray_err_set", 128'(err_stray_rd), 128'd1);
        tick();
        tick();
        chk("stray_err_sticky", 128'(err_stray_rd), 128'd1);

        // Asynchronous reset in the middle of a locked body transfer.
        h_word[1]    = hdr(1, 1'b1);
        p_h_empty[1] = 1'b0;
        p_b_empty[1] = 1'b0;
        tick();
        chk("ar_gnt", 128'({gnt_valid, gnt_idx}), 128'({1'b1, 3'd1}));
        f_b_rden = 1'b1;
        #1;
        chk("ar_p_b_rden", 128'(p_b_rden), 128'b0010);
        #2;
        arst_n = 1'b0;
        #1;
        chk("ar_gnt_valid", 128'(gnt_valid), 128'd0);
        chk("ar_rden", 128'({p_h_rden, p_b_rden}), 128'd0);
        chk("ar_frame_cnt", 128'(frame_cnt), 128'd0);
        chk("ar_f_h_empty", 128'(f_h_empty), 128'd1);
        f_b_rden = 1'b0;
        tick();
        arst_n = 1'b1;
        tick();
        chk("ar_regrant", 128'({gnt_valid, gnt_idx}), 128'({1'b1, 3'd1}));
        chk("ar_f_h_dout", f_h_dout, hdr(1, 1'b1));

        // Header and body pops together: both forwarded, then release.
        f_h_rden = 1'b1;
        f_b_rden = 1'b1;
        #1;
        chk("both_rden", 128'({p_h_rden, p_b_rden}), 128'({4'b0010, 4'b0010}));
        tick();
        f_h_rden = 1'b0;
        f_b_rden = 1'b0;
        p_h_empty[1] = 1'b1;
        #1;
        chk("both_release", 128'({gnt_valid, frame_cnt}), 128'({1'b0, 16'd1}));
        chk("both_no_stray", 128'(err_stray_rd), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
